mcpu_core_scoreboard_cnt: RTL and testbench
===========================================

Name: mcpu_core_scoreboard_cnt

Overview:
Parametrised, counter-based successor to the core register/predicate scoreboard. Each tracked register and predicate has a small pending-write counter, so several in-flight writes to one destination (WAW) are tracked exactly rather than collapsed to one bit. Sits between decode (issue side) and writeback, and gives decode a per-register busy mask plus a back-pressure flag.

Parameters:
NREGS, 32, number of GPRs tracked
NPREDS, 3, number of predicates tracked (pred index = rd_num[1:0]; index >= NPREDS ignored)
LANES, 4, issue/writeback lanes per bundle
REG_W, 5, register number width (clog2 NREGS)
CNT_W, 2, counter width; CMAX = 2^CNT_W-1 outstanding writes per destination

Ports:
clkrst_core_clk  in  1  core clock
clkrst_core_rst_n  in  1  reset; asynchronous, active-low
d2sb_rd_num  in  LANES*REG_W  issue destination numbers, lane k at [k*REG_W +: REG_W]
d2sb_rd_we  in  LANES  issue lane writes a GPR
d2sb_pred_we  in  LANES  issue lane writes a predicate
d2sb_progress  in  1  issue bundle accepted this cycle
wb2sb_rd_num  in  LANES*REG_W  writeback destination numbers
wb2sb_rd_we  in  LANES  writeback lane commits a GPR
wb2sb_pred_we  in  LANES  writeback lane commits a predicate
exception  in  1  squash the most recently accepted bundle
pipe_flush  in  1  mask this cycle's issue increments
sb2d_reg_scoreboard  out  NREGS  bit i = GPR i has a pending write
sb2d_pred_scoreboard  out  NPREDS  bit i = predicate i has a pending write
sb2d_full  out  1  some counter cannot absorb a worst-case bundle

Behaviour:
- Reset: all counters, last_inc, registered wb decrements = 0; all outputs 0.
- inc_i: number of lanes with we & ~pipe_flush targeting i; duplicates within one bundle each count.
- dec_i: number of wb lanes committing i. Registered one cycle as dec_q_i (mirrors existing one-cycle wb latency).
- eff_i = max(cnt_i - dec_q_i, 0). Scoreboard bit i = (eff_i != 0), combinational from state.
- next cnt_i = clamp(eff_i + (progress ? inc_i : 0) - (exception ? last_inc_i : 0), 0, CMAX); arithmetic in CNT_W+3 bits, signed.
- last_inc: loaded with inc on progress; cleared on exception without progress (no double squash); exception with progress loads the new bundle.
- sb2d_full = any eff_i > CMAX - LANES (GPRs and preds). Decode must not assert progress while full; if it does, counters saturate at CMAX.
- Underflow (wb to a counter at 0): clamp to 0, no other side effect.
- pipe_flush: no counter cleared; in-flight writes still decrement on writeback.
- Reset mid-operation: all state cleared asynchronously; no pending writes survive.

Optional Feature:
MCPU_CORE_SB_WB_BYPASS_EN: when defined, dec_i is applied combinationally the same cycle (eff_i = cnt_i - dec_i), so a register clears in the cycle of its writeback; dec_q registers removed. When undefined, one-cycle registered decrement as above.

Test Plan:
- Issue lane0 rd=5 with progress; next cycle scoreboard = 0x20; wb rd=5 at T; bit 5 clear at T+1 (T with bypass).
- Two bundles both writing r7 (cnt=2); one wb -> bit 7 still set; second wb -> clear.
- Issue r3 and pred 1 with progress, exception next cycle -> r3/pred1 bits clear; second exception -> no change, no underflow.
- pipe_flush with progress, rd_we=1 on r9 -> r9 never set.
- CNT_W=2, LANES=4: one r2 write pending -> sb2d_full=1 (1 > 3-4); issue r0 with pred_we and rd_num=3 -> pred mask unchanged.
- Same cycle: wb dec r4 (cnt 1->0), new issue r4, exception squashing prior r4 write with cnt=2 -> result clamps to defined value per formula (1).

Source files
------------

// File: rtl/mcpu_core_scoreboard_cnt_if.sv
// Decode/writeback <-> counter scoreboard interface.
// master: decode/writeback side driving issue and commit information.
// slave : scoreboard side returning busy masks and back-pressure.
interface mcpu_core_scoreboard_cnt_if #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NPREDS = 3,
  parameter int unsigned LANES  = 4,
  parameter int unsigned REG_W  = 5
);
  logic [LANES*REG_W-1:0] d2sb_rd_num;
  logic [LANES-1:0]       d2sb_rd_we;
  logic [LANES-1:0]       d2sb_pred_we;
  logic                   d2sb_progress;
  logic [LANES*REG_W-1:0] wb2sb_rd_num;
  logic [LANES-1:0]       wb2sb_rd_we;
  logic [LANES-1:0]       wb2sb_pred_we;
  logic                   exception;
  logic                   pipe_flush;
  logic [NREGS-1:0]       sb2d_reg_scoreboard;
  logic [NPREDS-1:0]      sb2d_pred_scoreboard;
  logic                   sb2d_full;

  modport master (
    output d2sb_rd_num, d2sb_rd_we, d2sb_pred_we, d2sb_progress,
    output wb2sb_rd_num, wb2sb_rd_we, wb2sb_pred_we,
    output exception, pipe_flush,
    input  sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb2d_full
  );

  modport slave (
    input  d2sb_rd_num, d2sb_rd_we, d2sb_pred_we, d2sb_progress,
    input  wb2sb_rd_num, wb2sb_rd_we, wb2sb_pred_we,
    input  exception, pipe_flush,
    output sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb2d_full
  );
endinterface

// File: rtl/mcpu_core_scoreboard_cnt.sv
// Counter-based register/predicate scoreboard.
// Each GPR and predicate owns a CNT_W-bit pending-write counter so that
// multiple in-flight writes to one destination are tracked exactly.
// Optional macro MCPU_CORE_SB_WB_BYPASS_EN: apply writeback decrements in the
// same cycle instead of through a one-cycle register.
module mcpu_core_scoreboard_cnt #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NPREDS = 3,
  parameter int unsigned LANES  = 4,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 2
) (
  input logic                      clkrst_core_clk,
  input logic                      clkrst_core_rst_n,
  mcpu_core_scoreboard_cnt_if.slave sb_if
);

  // Counters 0..NREGS-1 are GPRs, NREGS..NREGS+NPREDS-1 are predicates.
  localparam int unsigned NCNT     = NREGS + NPREDS;
  localparam int unsigned AW       = CNT_W + 3;
  localparam int unsigned LW       = $clog2(LANES + 1);
  localparam int          CMAX     = (1 << CNT_W) - 1;
  localparam int          FULL_THR = CMAX - int'(LANES);
  localparam logic signed [AW-1:0] CMAX_S = AW'(CMAX);

  logic [CNT_W-1:0]     cnt_q      [NCNT];
  logic [CNT_W-1:0]     cnt_d      [NCNT];
  logic [LW-1:0]        last_inc_q [NCNT];
  logic [LW-1:0]        last_inc_d [NCNT];
  logic [LW-1:0]        inc_c      [NCNT];
  logic [LW-1:0]        dec_c      [NCNT];
  logic [LW-1:0]        dec_use    [NCNT];
  logic signed [AW-1:0] eff        [NCNT];
  logic                 full_q;
  logic                 full_d;
  logic [NREGS-1:0]     reg_sb;
  logic [NPREDS-1:0]    pred_sb;

  // Per-destination issue increments and writeback decrements for this cycle.
  always_comb begin
    for (int i = 0; i < int'(NCNT); i++) begin
      inc_c[i] = '0;
      dec_c[i] = '0;
    end
    for (int k = 0; k < int'(LANES); k++) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (sb_if.d2sb_rd_we[k] && !sb_if.pipe_flush &&
            sb_if.d2sb_rd_num[k*REG_W +: REG_W] == REG_W'(i))
          inc_c[i] = inc_c[i] + LW'(1);
        if (sb_if.wb2sb_rd_we[k] &&
            sb_if.wb2sb_rd_num[k*REG_W +: REG_W] == REG_W'(i))
          dec_c[i] = dec_c[i] + LW'(1);
      end
      for (int p = 0; p < int'(NPREDS); p++) begin
        if (sb_if.d2sb_pred_we[k] && !sb_if.pipe_flush &&
            sb_if.d2sb_rd_num[k*REG_W +: 2] == 2'(p))
          inc_c[int'(NREGS) + p] = inc_c[int'(NREGS) + p] + LW'(1);
        if (sb_if.wb2sb_pred_we[k] &&
            sb_if.wb2sb_rd_num[k*REG_W +: 2] == 2'(p))
          dec_c[int'(NREGS) + p] = dec_c[int'(NREGS) + p] + LW'(1);
      end
    end
  end

`ifdef MCPU_CORE_SB_WB_BYPASS_EN
  // Writeback decrements take effect in the cycle they arrive.
  assign dec_use = dec_c;
`else
  logic [LW-1:0] dec_q [NCNT];

  // Writeback decrements are applied one cycle after they arrive.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      for (int i = 0; i < int'(NCNT); i++) dec_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NCNT); i++) dec_q[i] <= dec_c[i];
    end
  end

  assign dec_use = dec_q;
`endif

  // Effective count, next count, squash bookkeeping and full look-ahead.
  always_comb begin
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] nxt;
    full_d = 1'b0;
    for (int i = 0; i < int'(NCNT); i++) begin
      eff[i] = $signed(AW'(cnt_q[i])) - $signed(AW'(dec_use[i]));
      if (eff[i] < 0) eff[i] = '0;
      sum = eff[i];
      if (sb_if.d2sb_progress) sum = sum + $signed(AW'(inc_c[i]));
      if (sb_if.exception)     sum = sum - $signed(AW'(last_inc_q[i]));
      if (sum < 0)
        sum = '0;
      else if (sum > CMAX_S)
        sum = CMAX_S;
      cnt_d[i] = CNT_W'(sum);
      if (sb_if.d2sb_progress)
        last_inc_d[i] = inc_c[i];
      else if (sb_if.exception)
        last_inc_d[i] = '0;
      else
        last_inc_d[i] = last_inc_q[i];
`ifdef MCPU_CORE_SB_WB_BYPASS_EN
      nxt = sum;
`else
      // Next cycle's effective count subtracts this cycle's writebacks.
      nxt = sum - $signed(AW'(dec_c[i]));
      if (nxt < 0) nxt = '0;
`endif
      if (int'(nxt) > FULL_THR) full_d = 1'b1;
    end
  end

  // Busy masks: any remaining pending write marks the destination busy.
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++)
      reg_sb[i] = (eff[i] != '0);
    for (int p = 0; p < int'(NPREDS); p++)
      pred_sb[p] = (eff[int'(NREGS) + p] != '0);
  end

  // Counter, last-bundle and full state.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      for (int i = 0; i < int'(NCNT); i++) begin
        cnt_q[i]      <= '0;
        last_inc_q[i] <= '0;
      end
      full_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NCNT); i++) begin
        cnt_q[i]      <= cnt_d[i];
        last_inc_q[i] <= last_inc_d[i];
      end
      full_q <= full_d;
    end
  end

  assign sb_if.sb2d_reg_scoreboard  = reg_sb;
  assign sb_if.sb2d_pred_scoreboard = pred_sb;
  assign sb_if.sb2d_full            = full_q;

endmodule

// File: tb/tb_mcpu_core_scoreboard_cnt.sv
// Self-checking bench for mcpu_core_scoreboard_cnt with a count-based model.
module tb_mcpu_core_scoreboard_cnt;

  localparam int NREGS  = 32;
  localparam int NPREDS = 3;
  localparam int LANES  = 4;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 2;
  localparam int NCNT   = NREGS + NPREDS;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef MCPU_CORE_SB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [LANES*REG_W-1:0] d_num, w_num;
  logic [LANES-1:0]       d_rwe, d_pwe, w_rwe, w_pwe;
  logic                   prog, exc, flush;

  mcpu_core_scoreboard_cnt_if #(.NREGS(NREGS), .NPREDS(NPREDS), .LANES(LANES), .REG_W(REG_W)) sb_if ();

  assign sb_if.d2sb_rd_num   = d_num;
  assign sb_if.d2sb_rd_we    = d_rwe;
  assign sb_if.d2sb_pred_we  = d_pwe;
  assign sb_if.d2sb_progress = prog;
  assign sb_if.wb2sb_rd_num  = w_num;
  assign sb_if.wb2sb_rd_we   = w_rwe;
  assign sb_if.wb2sb_pred_we = w_pwe;
  assign sb_if.exception     = exc;
  assign sb_if.pipe_flush    = flush;

  mcpu_core_scoreboard_cnt #(.NREGS(NREGS), .NPREDS(NPREDS), .LANES(LANES), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .sb_if             (sb_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pending writes per destination, last bundle, pending wb.
  int m_cnt  [NCNT];
  int m_decq [NCNT];
  int m_last [NCNT];
  bit m_live;

  function automatic int lane_num(input logic [LANES*REG_W-1:0] v, input int k);
    logic [REG_W-1:0] x;
    x = v[k*REG_W +: REG_W];
    return int'(x);
  endfunction

  function automatic int inc_of(input int idx);
    int n = 0;
    if (flush) return 0;
    for (int k = 0; k < LANES; k++) begin
      if (idx < NREGS) begin
        if (d_rwe[k] && lane_num(d_num, k) == idx) n++;
      end else begin
        if (d_pwe[k] && (lane_num(d_num, k) % 4) == idx - NREGS) n++;
      end
    end
    return n;
  endfunction

  function automatic int dec_of(input int idx);
    int n = 0;
    for (int k = 0; k < LANES; k++) begin
      if (idx < NREGS) begin
        if (w_rwe[k] && lane_num(w_num, k) == idx) n++;
      end else begin
        if (w_pwe[k] && (lane_num(w_num, k) % 4) == idx - NREGS) n++;
      end
    end
    return n;
  endfunction

  function automatic int eff_now(input int idx);
    int e;
    e = m_cnt[idx] - (BYPASS ? dec_of(idx) : m_decq[idx]);
    return (e < 0) ? 0 : e;
  endfunction

  function automatic logic [NREGS-1:0] exp_reg();
    logic [NREGS-1:0] m = '0;
    for (int i = 0; i < NREGS; i++) m[i] = (eff_now(i) != 0);
    return m;
  endfunction

  function automatic logic [NPREDS-1:0] exp_pred();
    logic [NPREDS-1:0] m = '0;
    for (int p = 0; p < NPREDS; p++) m[p] = (eff_now(NREGS + p) != 0);
    return m;
  endfunction

  function automatic logic exp_full();
    if (!m_live) return 1'b0;
    for (int i = 0; i < NCNT; i++)
      if (eff_now(i) > CMAX - LANES) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    d_num = '0; w_num = '0;
    d_rwe = '0; d_pwe = '0; w_rwe = '0; w_pwe = '0;
    prog = 1'b0; exc = 1'b0; flush = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCNT; i++) begin
      m_cnt[i] = 0; m_decq[i] = 0; m_last[i] = 0;
    end
    m_live = 1'b0;
  endtask

  // One clock with the currently driven inputs, then return to idle inputs.
  task automatic tick();
    int nc [NCNT];
    int nl [NCNT];
    int nd [NCNT];
    for (int i = 0; i < NCNT; i++) begin
      int n;
      n = eff_now(i) + (prog ? inc_of(i) : 0) - (exc ? m_last[i] : 0);
      if (n < 0) n = 0;
      if (n > CMAX) n = CMAX;
      nc[i] = n;
      nl[i] = prog ? inc_of(i) : (exc ? 0 : m_last[i]);
      nd[i] = dec_of(i);
    end
    @(posedge clk);
    m_cnt  = nc;
    m_last = nl;
    m_decq = nd;
    m_live = 1'b1;
    #1 idle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    model_clear();
    #1;
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h0 || sb_if.sb2d_pred_scoreboard !== 3'b000 || sb_if.sb2d_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: reg=%h pred=%b full=%b, want 0/0/0",
               sb_if.sb2d_reg_scoreboard, sb_if.sb2d_pred_scoreboard, sb_if.sb2d_full);
    end
    do_reset();
  endtask

  task automatic test_issue_wb();
    do_reset();
    d_num[0 +: REG_W] = 5'd5; d_rwe = 4'b0001; prog = 1'b1;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h20) begin
      n_fail++; $display("FAIL issue_r5: reg=%h want %h", sb_if.sb2d_reg_scoreboard, 32'h20);
    end
    w_num[0 +: REG_W] = 5'd5; w_rwe = 4'b0001;
    #1;
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== (BYPASS ? 32'h0 : 32'h20)) begin
      n_fail++; $display("FAIL wb_r5_same_cycle: reg=%h want %h", sb_if.sb2d_reg_scoreboard, BYPASS ? 32'h0 : 32'h20);
    end
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h0) begin
      n_fail++; $display("FAIL wb_r5_after: reg=%h want 0", sb_if.sb2d_reg_scoreboard);
    end
  endtask

  task automatic test_waw();
    do_reset();
    for (int b = 0; b < 2; b++) begin
      d_num[0 +: REG_W] = 5'd7; d_rwe = 4'b0001; prog = 1'b1;
      tick();
    end
    w_num[0 +: REG_W] = 5'd7; w_rwe = 4'b0001;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h80) begin
      n_fail++; $display("FAIL waw_one_wb: reg=%h want %h", sb_if.sb2d_reg_scoreboard, 32'h80);
    end
    w_num[0 +: REG_W] = 5'd7; w_rwe = 4'b0001;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h0) begin
      n_fail++; $display("FAIL waw_two_wb: reg=%h want 0", sb_if.sb2d_reg_scoreboard);
    end
  endtask

  task automatic test_exception();
    do_reset();
    d_num[0 +: REG_W] = 5'd3; d_rwe = 4'b0001;
    d_num[REG_W +: REG_W] = 5'd1; d_pwe = 4'b0010; prog = 1'b1;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h8 || sb_if.sb2d_pred_scoreboard !== 3'b010) begin
      n_fail++; $display("FAIL exc_issue: reg=%h pred=%b want %h/010", sb_if.sb2d_reg_scoreboard, sb_if.sb2d_pred_scoreboard, 32'h8);
    end
    for (int r = 0; r < 2; r++) begin
      exc = 1'b1;
      tick();
      n_tests++;
      if (sb_if.sb2d_reg_scoreboard !== 32'h0 || sb_if.sb2d_pred_scoreboard !== 3'b000) begin
        n_fail++; $display("FAIL exc_squash%0d: reg=%h pred=%b want 0/000", r, sb_if.sb2d_reg_scoreboard, sb_if.sb2d_pred_scoreboard);
      end
    end
    d_num[0 +: REG_W] = 5'd3; d_rwe = 4'b0001; prog = 1'b1;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h8) begin
      n_fail++; $display("FAIL exc_reissue: reg=%h want %h", sb_if.sb2d_reg_scoreboard, 32'h8);
    end
  endtask

  task automatic test_flush();
    do_reset();
    d_num[0 +: REG_W] = 5'd9; d_rwe = 4'b0001; prog = 1'b1; flush = 1'b1;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h0) begin
      n_fail++; $display("FAIL flush_r9: reg=%h want 0", sb_if.sb2d_reg_scoreboard);
    end
    exc = 1'b1;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h0) begin
      n_fail++; $display("FAIL flush_exc: reg=%h want 0", sb_if.sb2d_reg_scoreboard);
    end
  endtask

  task automatic test_full_pred();
    do_reset();
    n_tests++;
    if (sb_if.sb2d_full !== 1'b0) begin
      n_fail++; $display("FAIL full_post_reset: full=%b want 0", sb_if.sb2d_full);
    end
    d_num[0 +: REG_W] = 5'd2; d_rwe = 4'b0001; prog = 1'b1;
    tick();
    n_tests++;
    if (sb_if.sb2d_full !== 1'b1 || sb_if.sb2d_reg_scoreboard !== 32'h4) begin
      n_fail++; $display("FAIL full_r2: full=%b reg=%h want 1/%h", sb_if.sb2d_full, sb_if.sb2d_reg_scoreboard, 32'h4);
    end
    d_num[0 +: REG_W] = 5'd3; d_pwe = 4'b0001; prog = 1'b1;
    tick();
    n_tests++;
    if (sb_if.sb2d_pred_scoreboard !== 3'b000 || sb_if.sb2d_reg_scoreboard !== 32'h4) begin
      n_fail++; $display("FAIL pred_idx3: pred=%b reg=%h want 000/%h", sb_if.sb2d_pred_scoreboard, sb_if.sb2d_reg_scoreboard, 32'h4);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    d_num[0 +: REG_W] = 5'd4; d_rwe = 4'b0001; prog = 1'b1;
    tick();
    d_num[0 +: REG_W] = 5'd4; d_rwe = 4'b0001; prog = 1'b1;
    if (!BYPASS) begin w_num[0 +: REG_W] = 5'd4; w_rwe = 4'b0001; end
    tick();
    d_num[0 +: REG_W] = 5'd4; d_rwe = 4'b0001; prog = 1'b1; exc = 1'b1;
    if (BYPASS) begin w_num[0 +: REG_W] = 5'd4; w_rwe = 4'b0001; end
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h10) begin
      n_fail++; $display("FAIL same_cycle_r4: reg=%h want %h", sb_if.sb2d_reg_scoreboard, 32'h10);
    end
    tick();
    exc = 1'b1;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h0) begin
      n_fail++; $display("FAIL same_cycle_squash: reg=%h want 0", sb_if.sb2d_reg_scoreboard);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_num = {5'd1, 5'd2, 5'd3, 5'd1}; d_rwe = 4'b1111; d_pwe = 4'b0011; prog = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h0 || sb_if.sb2d_pred_scoreboard !== 3'b000 || sb_if.sb2d_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: reg=%h pred=%b full=%b want 0/000/0",
                         sb_if.sb2d_reg_scoreboard, sb_if.sb2d_pred_scoreboard, sb_if.sb2d_full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tick();
    n_tests++;
    if (sb_if.sb2d_reg_scoreboard !== 32'h0 || sb_if.sb2d_pred_scoreboard !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_after: reg=%h pred=%b want 0/000", sb_if.sb2d_reg_scoreboard, sb_if.sb2d_pred_scoreboard);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < LANES; k++) begin
        d_num[k*REG_W +: REG_W] = REG_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
        w_num[k*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
      end
      d_rwe = LANES'($urandom & $urandom);
      d_pwe = LANES'($urandom & $urandom);
      w_rwe = LANES'($urandom & $urandom);
      w_pwe = LANES'($urandom & $urandom & $urandom);
      prog  = ($urandom_range(0, 1) == 1);
      exc   = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      #1;
      n_tests++;
      if (sb_if.sb2d_reg_scoreboard !== exp_reg() || sb_if.sb2d_pred_scoreboard !== exp_pred()) begin
        n_fail++; $display("FAIL rand_mid c=%0d: reg=%h pred=%b want %h/%b", c,
                           sb_if.sb2d_reg_scoreboard, sb_if.sb2d_pred_scoreboard, exp_reg(), exp_pred());
      end
      tick();
      n_tests++;
      if (sb_if.sb2d_reg_scoreboard !== exp_reg() || sb_if.sb2d_pred_scoreboard !== exp_pred() ||
          sb_if.sb2d_full !== exp_full()) begin
        n_fail++; $display("FAIL rand_post c=%0d: reg=%h pred=%b full=%b want %h/%b/%b", c,
                           sb_if.sb2d_reg_scoreboard, sb_if.sb2d_pred_scoreboard, sb_if.sb2d_full,
                           exp_reg(), exp_pred(), exp_full());
      end
    end
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_waw();
    test_exception();
    test_flush();
    test_full_pred();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
